// File: rtl/cache_controller_pkg.sv
// cache_controller_pkg: shared cache geometry, miss-FSM states and block-address helper
package cache_controller_pkg;
  localparam int TAG_W = 25;
  localparam int INDEX_W = 3;
  localparam int OFFSET_W = 4;
  localparam int BLOCK_W = 128;
  typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, FILL} state_t;
  function automatic logic [31:0] block_addr(input logic [TAG_W-1:0] tag, input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/cache_controller.sv
// cache_controller: write-back/refill miss FSM between the direct-mapped cache arrays and data memory
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int TAG_W = cache_controller_pkg::TAG_W,
  parameter int INDEX_W = cache_controller_pkg::INDEX_W,
  parameter int OFFSET_W = cache_controller_pkg::OFFSET_W,
  parameter int BLOCK_W = cache_controller_pkg::BLOCK_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        address,
  input  logic [7:0]         writedata,
  output logic               controllerBusywait,
  input  logic               mem_BusyWait,
  input  logic [TAG_W-1:0]   Tag1,
  input  logic [BLOCK_W-1:0] writedata1,
  input  logic [TAG_W-1:0]   Tag,
  input  logic [INDEX_W-1:0] Index,
  input  logic               hit,
  input  logic               dirty,
  output logic               mem_Read,
  output logic               mem_Write,
  output logic [BLOCK_W-1:0] mem_Writedata,
  output logic [31:0]        mem_Address
);
  state_t state, next_state;
  logic access, unused_ok;
  assign access = read | write;
  assign unused_ok = ^{address, writedata, OFFSET_W[0]};
  always_ff @(posedge clock)
    state <= !reset ? IDLE : next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       next_state = access & ~hit ? (dirty ? WRITE_BACK : MEM_READ) : IDLE;
      WRITE_BACK: next_state = mem_BusyWait ? WRITE_BACK : MEM_READ;
      MEM_READ:   next_state = mem_BusyWait ? MEM_READ : FILL;
      default:    next_state = IDLE;
    endcase
  end
  // the stall is raised combinationally in the miss-detect cycle so the CPU never runs ahead
  always_comb begin
    mem_Write = state == WRITE_BACK;
    mem_Read = state == MEM_READ;
    mem_Address = mem_Write ? block_addr(Tag1, Index) : mem_Read ? block_addr(Tag, Index) : '0;
    mem_Writedata = mem_Write ? writedata1 : '0;
    controllerBusywait = reset & (state == IDLE ? access & ~hit : 1'b1);
  end
endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed and randomized miss sequences against a latency-count model
module tb_cache_controller;
  logic clock = 0, reset = 0, read = 0, write = 0, hit = 0, dirty = 0;
  logic [31:0] address = 0;
  logic [7:0] writedata = 0;
  logic [24:0] Tag = 0, Tag1 = 0;
  logic [2:0] Index = 0;
  logic [127:0] writedata1 = 0, mem_Writedata;
  logic controllerBusywait, mem_BusyWait, mem_Read, mem_Write;
  logic [31:0] mem_Address;
  int lat = 5, mcnt = 0, checks = 0, errors = 0;

  cache_controller dut (
    .clock(clock), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .controllerBusywait(controllerBusywait), .mem_BusyWait(mem_BusyWait),
    .Tag1(Tag1), .writedata1(writedata1), .Tag(Tag), .Index(Index), .hit(hit), .dirty(dirty),
    .mem_Read(mem_Read), .mem_Write(mem_Write), .mem_Writedata(mem_Writedata), .mem_Address(mem_Address)
  );

  always #5 clock = ~clock;

  // memory answers each request after exactly lat cycles, busy from the first cycle
  assign mem_BusyWait = (mem_Read | mem_Write) && (mcnt != lat - 1);
  always @(posedge clock)
    mcnt <= (!(mem_Read | mem_Write) || !mem_BusyWait) ? 0 : mcnt + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_miss(input logic rd, input logic wr, input logic h, input logic d,
                          input logic [24:0] tg, input logic [24:0] tg1, input logic [2:0] idx,
                          input logic [127:0] wd, input int m);
    int stall, nw, nr;
    logic miss;
    logic [31:0] got_wb, got_rd;
    logic [127:0] got_wd;
    got_wb = 'x;
    got_rd = 'x;
    got_wd = 'x;
    @(negedge clock);
    lat = m;
    read = rd; write = wr; hit = h; dirty = d; Tag = tg; Tag1 = tg1; Index = idx; writedata1 = wd;
    address = $urandom; writedata = 8'($urandom);
    #1;
    miss = (rd | wr) & ~h;
    chk("detect_busy", controllerBusywait, miss);
    chk("idle_nomem", {mem_Read, mem_Write}, 0);
    if (miss) begin
      stall = 1; nw = 0; nr = 0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clock);
        #1;
        read = 0; write = 0; hit = 1'($urandom); dirty = 1'($urandom);
        #1;
        chk("excl", mem_Read & mem_Write, 0);
        if (!controllerBusywait) break;
        stall++;
        if (mem_Write) begin nw++; got_wb = mem_Address; got_wd = mem_Writedata; end
        if (mem_Read) begin nr++; got_rd = mem_Address; end
      end
      chk("done", controllerBusywait, 0);
      chk("stall", stall, 2 + m * (d ? 2 : 1));
      chk("wr_cycles", nw, d ? m : 0);
      chk("rd_cycles", nr, m);
      chk("rd_addr", got_rd, {tg, idx, 4'b0});
      if (d) begin
        chk("wb_addr", got_wb, {tg1, idx, 4'b0});
        chk("wb_data", got_wd, wd);
      end
      hit = 0;
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", controllerBusywait, 0);
    chk("rst_mem", {mem_Read, mem_Write, mem_Address, mem_Writedata}, 0);
    @(negedge clock);
    reset = 1;
    run_miss(1, 0, 0, 0, 25'h1, 25'h7, 3'd2, 128'h5, 5);
    run_miss(0, 1, 0, 1, 25'h9, 25'h3, 3'd1, 128'hDEADBEEF_00000000_11111111_CAFEF00D, 5);
    run_miss(1, 0, 1, 0, 25'h4, 25'h4, 3'd3, 128'h0, 5);
    run_miss(1, 1, 0, 0, 25'h2A, 25'h0, 3'd7, 128'h0, 3);
    // reset in the middle of a refill
    @(negedge clock);
    lat = 5; read = 1; hit = 0; dirty = 0; Tag = 25'h1; Index = 3'd2;
    @(posedge clock);
    #1;
    read = 0;
    chk("mr_read", mem_Read, 1);
    chk("mr_addr", mem_Address, 32'h000000A0);
    @(negedge clock);
    reset = 0;
    #1;
    chk("rst_gate_busy", controllerBusywait, 0);
    repeat (2) begin
      @(posedge clock);
      #1;
      chk("rst_mr_busy", controllerBusywait, 0);
      chk("rst_mr_mem", {mem_Read, mem_Write, mem_Address, mem_Writedata}, 0);
    end
    @(negedge clock);
    reset = 1;
    // reset in the middle of a write-back
    @(negedge clock);
    write = 1; dirty = 1; Tag1 = 25'h3; Index = 3'd1; writedata1 = 128'h1234;
    @(posedge clock);
    #1;
    write = 0;
    chk("wb_write", mem_Write, 1);
    chk("wb_addr_d", mem_Address, 32'h00000190);
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1;
    chk("rst_wb_write", mem_Write, 0);
    chk("rst_wb_busy", controllerBusywait, 0);
    @(negedge clock);
    reset = 1;
    dirty = 0;
    for (int n = 0; n < 40; n++)
      run_miss(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
               25'($urandom), 25'($urandom), 3'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, $urandom_range(2, 6));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
